// File: rtl/mem_pkg.sv
// Shared types and sizing helpers for the banked scratchpad.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_pkg;

   localparam int WORD_BITS     = 32;
   localparam int DEF_ROWS      = 256;
   localparam int DEF_ROW_WORDS = 4;
   localparam int DEF_LEN_W     = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } burst_state_e;

   typedef enum logic {
      SEL_SB = 1'b0,
      SEL_IF = 1'b1
   } arb_sel_e;

   // Width of one array row in bits.
   function automatic int row_bits(input int row_words);
      return row_words * WORD_BITS;
   endfunction

   // Width of a row index.
   function automatic int row_idx_w(input int rows);
      return $clog2(rows);
   endfunction

   // Width of a 32-bit word index covering the whole array.
   function automatic int word_idx_w(input int rows, input int row_words);
      return $clog2(rows * row_words);
   endfunction

endpackage

// File: rtl/sram_bank.sv
// Single-port row array with per-byte write enables and a registered read port.
// Latency: read data valid the cycle after rd_en; rd_data holds between reads.
// Backpressure: none, accepts one access every cycle.
module sram_bank
   import mem_pkg::*;
#(
   parameter int ROWS     = DEF_ROWS,
   parameter int ROW_BITS = DEF_ROW_WORDS * WORD_BITS
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    rd_en,
   input  logic [ROW_BITS/8-1:0]   wr_be,
   input  logic [$clog2(ROWS)-1:0] addr,
   input  logic [ROW_BITS-1:0]     wr_data,
   output logic [ROW_BITS-1:0]     rd_data
);

   logic [ROW_BITS-1:0] mem [ROWS];

   // Byte-granular write; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      for (int b = 0; b < ROW_BITS/8; b++) begin
         if (wr_be[b]) begin
            mem[addr][b*8 +: 8] <= wr_data[b*8 +: 8];
         end
      end
   end

   // Registered read, cleared in reset so outputs start at zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[addr];
      end
   end

endmodule

// File: rtl/banked_scratchpad_arb.sv
// Shared scratchpad: single-word system bus port and multi-row burst port, round-robin arbitrated.
// Latency: read data and sb_err one cycle after grant; if_done the cycle after the last beat ack.
// Backpressure: sb_req_ready/if_beat_ack grant one access per cycle; if_req_ready only in IDLE.
module banked_scratchpad_arb
   import mem_pkg::*;
#(
   parameter int ROWS      = DEF_ROWS,
   parameter int ROW_WORDS = DEF_ROW_WORDS,
   parameter int LEN_W     = DEF_LEN_W
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            sb_req_valid,
   output logic                            sb_req_ready,
   input  logic                            sb_rdwr,
   input  logic [31:0]                     sb_addr,
   input  logic [3:0]                      sb_mask,
   input  logic [31:0]                     sb_wr_data,
   output logic                            sb_rd_valid,
   output logic [31:0]                     sb_rd_data,
   output logic                            sb_err,
   input  logic                            if_req_valid,
   output logic                            if_req_ready,
   input  logic                            if_rdwr,
   input  logic [31:0]                     if_addr,
   input  logic [LEN_W-1:0]                if_len,
   input  logic [ROW_WORDS*WORD_BITS-1:0]  if_wr_data,
   output logic                            if_beat_ack,
   output logic                            if_rd_valid,
   output logic [ROW_WORDS*WORD_BITS-1:0]  if_rd_data,
   output logic                            if_busy,
   output logic                            if_done
);

   localparam int ROW_BITS = row_bits(ROW_WORDS);
   localparam int ROW_AW   = row_idx_w(ROWS);
   localparam int WIDX_W   = word_idx_w(ROWS, ROW_WORDS);
   localparam int LANE_W   = WIDX_W - ROW_AW;   // ROW_WORDS must be a power of 2, >= 2
   localparam int BE_W     = ROW_BITS / 8;
   localparam int BYTE_OFF = LANE_W + 2;

   typedef struct packed {
      logic              rdwr;
      logic [ROW_AW-1:0] row;
      logic [LEN_W-1:0]  cnt;
   } burst_ctx_t;

   burst_state_e state_q, state_d;
   burst_ctx_t   ctx_q, ctx_d;
   arb_sel_e     last_q;

   logic [29:0]         sb_widx;
   logic                sb_oor;
   logic [LANE_W-1:0]   sb_lane;
   logic [ROW_AW-1:0]   sb_row;
   logic [BE_W-1:0]     sb_be;
   logic                sb_vld, if_vld, gnt_sb, gnt_if;
   logic [ROW_AW-1:0]   mem_addr;
   logic [ROW_BITS-1:0] mem_wdata, mem_rdata;
   logic [BE_W-1:0]     mem_be;
   logic                mem_rd;
   logic                sb_oor_q;
   logic [LANE_W-1:0]   sb_lane_q;
   logic [31:0]         sb_word, sb_hold_q;
   logic [ROW_BITS-1:0] if_hold_q;
   logic                unused_addr_bits;

   // System bus decode: word index, lane, row and range check.
   assign sb_widx = sb_addr[31:2];
   assign sb_oor  = (sb_widx >> WIDX_W) != '0;
   assign sb_lane = sb_widx[LANE_W-1:0];
   assign sb_row  = sb_widx[LANE_W +: ROW_AW];
   assign sb_be   = BE_W'(sb_mask) << {sb_lane, 2'b00};

   // Byte offset bits and high burst address bits carry no meaning here.
   assign unused_addr_bits = ^{sb_addr[1:0], if_addr};

   // Round-robin: an uncontested requester always wins; a contest goes to the other port.
   assign sb_vld = rst_n & sb_req_valid;
   assign if_vld = rst_n & (state_q == BURST);
   assign gnt_sb = sb_vld & (~if_vld | (last_q == SEL_IF));
   assign gnt_if = if_vld & (~sb_vld | (last_q == SEL_SB));

   assign sb_req_ready = gnt_sb;
   assign if_beat_ack  = gnt_if;
   assign if_req_ready = rst_n & (state_q == IDLE);
   assign if_busy      = if_vld;

   // Array access mux: steer the granted port onto the single array port.
   always_comb begin
      mem_addr  = ctx_q.row;
      mem_wdata = if_wr_data;
      mem_be    = '0;
      mem_rd    = 1'b0;
      if (gnt_sb) begin
         mem_addr  = sb_row;
         mem_wdata = {ROW_WORDS{sb_wr_data}};
         if (!sb_oor) begin
            if (sb_rdwr) mem_be = sb_be;
            else         mem_rd = 1'b1;
         end
      end else if (gnt_if) begin
         if (ctx_q.rdwr) mem_be = '1;
         else            mem_rd = 1'b1;
      end
   end

   sram_bank #(
      .ROWS     (ROWS),
      .ROW_BITS (ROW_BITS)
   ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .rd_en   (mem_rd),
      .wr_be   (mem_be),
      .addr    (mem_addr),
      .wr_data (mem_wdata),
      .rd_data (mem_rdata)
   );

   // Burst FSM next state: latch the request in IDLE, step row/count on each granted beat.
   always_comb begin
      state_d = state_q;
      ctx_d   = ctx_q;
      case (state_q)
         IDLE: begin
            if (if_req_ready && if_req_valid) begin
               state_d    = BURST;
               ctx_d.rdwr = if_rdwr;
               ctx_d.row  = if_addr[BYTE_OFF +: ROW_AW];
               ctx_d.cnt  = if_len;
            end
         end
         BURST: begin
            if (gnt_if) begin
               ctx_d.row = ctx_q.row + ROW_AW'(1);
               ctx_d.cnt = ctx_q.cnt - LEN_W'(1);
               if (ctx_q.cnt == '0) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Burst FSM state register; reset aborts any burst in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ctx_q   <= '0;
      end else begin
         state_q <= state_d;
         ctx_q   <= ctx_d;
      end
   end

   // Arbiter pointer moves only when both ports competed.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_q <= SEL_SB;
      end else if (sb_vld && if_vld) begin
         last_q <= gnt_sb ? SEL_SB : SEL_IF;
      end
   end

   // Response strobes, one cycle after the grant.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sb_rd_valid <= 1'b0;
         sb_err      <= 1'b0;
         sb_oor_q    <= 1'b0;
         sb_lane_q   <= '0;
         if_rd_valid <= 1'b0;
         if_done     <= 1'b0;
      end else begin
         sb_rd_valid <= gnt_sb & ~sb_rdwr;
         sb_err      <= gnt_sb & sb_oor;
         sb_oor_q    <= sb_oor;
         sb_lane_q   <= sb_lane;
         if_rd_valid <= gnt_if & ~ctx_q.rdwr;
         if_done     <= gnt_if & (ctx_q.cnt == '0);
      end
   end

   // Out-of-range reads return zero; otherwise pick the addressed lane.
   assign sb_word    = sb_oor_q ? 32'h0 : mem_rdata[sb_lane_q*WORD_BITS +: WORD_BITS];
   assign sb_rd_data = sb_rd_valid ? sb_word : sb_hold_q;
   assign if_rd_data = if_rd_valid ? mem_rdata : if_hold_q;

   // Per-port hold registers so each port keeps its last read value while the other reads.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sb_hold_q <= '0;
         if_hold_q <= '0;
      end else begin
         if (sb_rd_valid) sb_hold_q <= sb_word;
         if (if_rd_valid) if_hold_q <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_banked_scratchpad_arb.sv
// Directed bench for banked_scratchpad_arb: reset, masked SB writes, bursts, arbitration, wrap, range, reset abort.
// Latency: checks read data one cycle after grant and if_done the cycle after the last beat.
// Backpressure: requests are held until the grant is observed, bounded by a retry limit.
module tb_banked_scratchpad_arb;

   localparam int ROWS      = 256;
   localparam int ROW_WORDS = 4;
   localparam int LEN_W     = 4;
   localparam int RB        = ROW_WORDS * 32;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             sb_req_valid = 1'b0, sb_req_ready, sb_rdwr = 1'b0;
   logic [31:0]      sb_addr = '0, sb_wr_data = '0, sb_rd_data;
   logic [3:0]       sb_mask = '0;
   logic             sb_rd_valid, sb_err;
   logic             if_req_valid = 1'b0, if_req_ready, if_rdwr = 1'b0;
   logic [31:0]      if_addr = '0;
   logic [LEN_W-1:0] if_len = '0;
   logic [RB-1:0]    if_wr_data = '0, if_rd_data;
   logic             if_beat_ack, if_rd_valid, if_busy, if_done;

   int n_checks = 0;
   int n_fail   = 0;

   int            wr_idx = 0;
   int            ack_cyc[$];
   int            sbg_cyc[$];
   logic [RB-1:0] rd_beats[$];
   int            rd_last_cyc, done_at;
   logic [31:0]   sb_rd_last;

   banked_scratchpad_arb #(.ROWS(ROWS), .ROW_WORDS(ROW_WORDS), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .sb_req_valid(sb_req_valid), .sb_req_ready(sb_req_ready), .sb_rdwr(sb_rdwr),
      .sb_addr(sb_addr), .sb_mask(sb_mask), .sb_wr_data(sb_wr_data),
      .sb_rd_valid(sb_rd_valid), .sb_rd_data(sb_rd_data), .sb_err(sb_err),
      .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_rdwr(if_rdwr),
      .if_addr(if_addr), .if_len(if_len), .if_wr_data(if_wr_data),
      .if_beat_ack(if_beat_ack), .if_rd_valid(if_rd_valid), .if_rd_data(if_rd_data),
      .if_busy(if_busy), .if_done(if_done)
   );

   always #5 clk = ~clk;

   // Beat k word w carries 0xC0DE0000 + 16*k + w.
   function automatic logic [RB-1:0] pat(input int k);
      logic [RB-1:0] r;
      for (int w = 0; w < ROW_WORDS; w++) r[w*32 +: 32] = 32'hC0DE0000 + 32'(k*16 + w);
      return r;
   endfunction

   // Present an SB request at a negedge, hold until granted; returns at the negedge after accept.
   task automatic sb_req(input logic wr, input logic [31:0] a, input logic [3:0] m,
                         input logic [31:0] d, output bit ok);
      bit rdy;
      int tries;
      sb_req_valid = 1'b1; sb_rdwr = wr; sb_addr = a; sb_mask = m; sb_wr_data = d;
      ok = 1'b0; tries = 0;
      while (!ok && tries < 16) begin
         #1 rdy = sb_req_ready;
         @(posedge clk); @(negedge clk);
         ok = rdy; tries++;
      end
      sb_req_valid = 1'b0;
   endtask

   // Present a burst request; returns at the negedge after accept (first BURST cycle).
   task automatic if_start(input logic wr, input logic [31:0] a, input logic [LEN_W-1:0] len,
                           output bit ok);
      bit rdy;
      int tries;
      if_req_valid = 1'b1; if_rdwr = wr; if_addr = a; if_len = len;
      ok = 1'b0; tries = 0;
      while (!ok && tries < 16) begin
         #1 rdy = if_req_ready;
         @(posedge clk); @(negedge clk);
         ok = rdy; tries++;
      end
      if_req_valid = 1'b0;
   endtask

   // Run n cycles from a negedge, supplying write beats and recording what the DUT did each cycle.
   task automatic run_cycles(input int n);
      bit ack_now;
      ack_cyc.delete(); sbg_cyc.delete(); rd_beats.delete();
      rd_last_cyc = -1; done_at = -1;
      for (int c = 0; c < n; c++) begin
         if_wr_data = pat(wr_idx);
         #1;
         ack_now = if_beat_ack;
         if (if_beat_ack)  ack_cyc.push_back(c);
         if (sb_req_ready) sbg_cyc.push_back(c);
         if (if_rd_valid) begin rd_beats.push_back(if_rd_data); rd_last_cyc = c; end
         if (if_done)      done_at = c;
         if (sb_rd_valid)  sb_rd_last = sb_rd_data;
         @(posedge clk);
         if (ack_now) wr_idx++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      sb_req_valid = 1'b1; if_req_valid = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      n_checks++;
      if ({sb_req_ready, sb_rd_valid, sb_err, if_req_ready, if_beat_ack, if_rd_valid, if_busy, if_done} !== 8'h0) begin
         n_fail++; $display("FAIL reset_flags: got %b want 00000000",
            {sb_req_ready, sb_rd_valid, sb_err, if_req_ready, if_beat_ack, if_rd_valid, if_busy, if_done});
      end
      n_checks++;
      if (sb_rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_sb_data: got %h want 0", sb_rd_data); end
      n_checks++;
      if (if_rd_data !== '0) begin n_fail++; $display("FAIL reset_if_data: got %h want 0", if_rd_data); end
      sb_req_valid = 1'b0; if_req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_checks++;
      if ({if_req_ready, sb_req_ready, if_busy} !== 3'b100) begin
         n_fail++; $display("FAIL release_ready: got %b want 100", {if_req_ready, sb_req_ready, if_busy});
      end
      @(negedge clk);
   endtask

   task automatic test_sb_mask();
      bit ok;
      sb_req(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, ok);
      n_checks++;
      if ({ok, sb_rd_valid, sb_err} !== 3'b100) begin
         n_fail++; $display("FAIL sb_wr1: ok/rd_valid/err got %b want 100", {ok, sb_rd_valid, sb_err});
      end
      sb_req(1'b1, 32'h10, 4'b0100, 32'h00AA0000, ok);
      n_checks++;
      if (ok !== 1'b1) begin n_fail++; $display("FAIL sb_wr2_grant: got %b want 1", ok); end
      sb_req(1'b0, 32'h10, 4'h0, 32'h0, ok);
      n_checks++;
      if ({ok, sb_rd_valid, sb_err} !== 3'b110) begin
         n_fail++; $display("FAIL sb_rd_strobes: got %b want 110", {ok, sb_rd_valid, sb_err});
      end
      n_checks++;
      if (sb_rd_data !== 32'hDEAABEEF) begin
         n_fail++; $display("FAIL sb_rd_merge: got %h want deaabeef", sb_rd_data);
      end
      @(negedge clk);
      n_checks++;
      if ({sb_rd_valid, sb_rd_data} !== {1'b0, 32'hDEAABEEF}) begin
         n_fail++; $display("FAIL sb_rd_hold: got %b/%h want 0/deaabeef", sb_rd_valid, sb_rd_data);
      end
   endtask

   task automatic test_back_to_back();
      bit ok, rdy_in_done;
      wr_idx = 0;
      if_start(1'b1, 32'h40, 4'd3, ok);
      run_cycles(4);
      n_checks++;
      if (ok !== 1'b1 || ack_cyc.size() != 4 || ack_cyc[3] != 3) begin
         n_fail++; $display("FAIL wr_burst_acks: got %0d acks want 4 at cycles 0..3", ack_cyc.size());
      end
      #1 rdy_in_done = if_req_ready;
      n_checks++;
      if ({if_done, rdy_in_done, if_busy} !== 3'b110) begin
         n_fail++; $display("FAIL done_cycle_ready: done/ready/busy got %b want 110", {if_done, rdy_in_done, if_busy});
      end
      if_start(1'b0, 32'h40, 4'd3, ok);
      run_cycles(6);
      n_checks++;
      if (ok !== 1'b1 || rd_beats.size() != 4 || done_at != 4 || rd_last_cyc != 4) begin
         n_fail++; $display("FAIL rd_burst_timing: beats %0d done %0d last_rd %0d want 4/4/4",
                            rd_beats.size(), done_at, rd_last_cyc);
      end
      for (int k = 0; k < 4 && k < rd_beats.size(); k++) begin
         n_checks++;
         if (rd_beats[k] !== pat(k)) begin
            n_fail++; $display("FAIL rd_burst_beat%0d: got %h want %h", k, rd_beats[k], pat(k));
         end
      end
      sb_req(1'b0, 32'h44, 4'h0, 32'h0, ok);
      n_checks++;
      if (sb_rd_data !== 32'hC0DE0001) begin
         n_fail++; $display("FAIL sb_rd_after_burst: got %h want c0de0001", sb_rd_data);
      end
   endtask

   task automatic test_arbitration();
      bit ok;
      int exp_sb[6];
      exp_sb = '{1, 3, 5, 7, 8, 9};
      if_start(1'b0, 32'h40, 4'd3, ok);
      sb_req_valid = 1'b1; sb_rdwr = 1'b0; sb_addr = 32'h44;
      run_cycles(10);
      sb_req_valid = 1'b0;
      n_checks++;
      if (ack_cyc.size() != 4 || ack_cyc[0] != 0 || ack_cyc[1] != 2 || ack_cyc[2] != 4 || ack_cyc[3] != 6) begin
         n_fail++; $display("FAIL arb_if_beats: got %0d acks, first %0d, want 0,2,4,6",
                            ack_cyc.size(), (ack_cyc.size() > 0) ? ack_cyc[0] : -1);
      end
      n_checks++;
      if (sbg_cyc.size() != 6) begin
         n_fail++; $display("FAIL arb_sb_count: got %0d want 6", sbg_cyc.size());
      end
      for (int i = 0; i < 6 && i < sbg_cyc.size(); i++) begin
         n_checks++;
         if (sbg_cyc[i] != exp_sb[i]) begin
            n_fail++; $display("FAIL arb_sb_grant%0d: cycle %0d want %0d", i, sbg_cyc[i], exp_sb[i]);
         end
      end
      n_checks++;
      if (done_at != 7 || rd_last_cyc != 7 || rd_beats.size() != 4) begin
         n_fail++; $display("FAIL arb_done: done %0d last_rd %0d beats %0d want 7/7/4",
                            done_at, rd_last_cyc, rd_beats.size());
      end
      n_checks++;
      if (sb_rd_last !== 32'hC0DE0001) begin
         n_fail++; $display("FAIL arb_sb_data: got %h want c0de0001", sb_rd_last);
      end
      @(negedge clk);
   endtask

   task automatic test_wrap_and_range();
      bit ok;
      logic [31:0] ra[4];
      logic [31:0] rv[4];
      ra = '{32'hFE0, 32'hFF8, 32'h00C, 32'h014};
      rv = '{32'hC0DE0080, 32'hC0DE0092, 32'hC0DE00A3, 32'hC0DE00B1};
      wr_idx = 8;
      if_start(1'b1, 32'hFE0, 4'd3, ok);
      run_cycles(5);
      n_checks++;
      if (ok !== 1'b1 || ack_cyc.size() != 4 || done_at != 4) begin
         n_fail++; $display("FAIL wrap_burst: acks %0d done %0d want 4/4", ack_cyc.size(), done_at);
      end
      for (int i = 0; i < 4; i++) begin
         sb_req(1'b0, ra[i], 4'h0, 32'h0, ok);
         n_checks++;
         if (sb_rd_data !== rv[i]) begin
            n_fail++; $display("FAIL wrap_row%0d: addr %h got %h want %h", i, ra[i], sb_rd_data, rv[i]);
         end
      end
      sb_req(1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, ok);
      n_checks++;
      if ({ok, sb_err, sb_rd_valid} !== 3'b110) begin
         n_fail++; $display("FAIL oor_wr_err: ok/err/rd_valid got %b want 110", {ok, sb_err, sb_rd_valid});
      end
      @(negedge clk);
      n_checks++;
      if (sb_err !== 1'b0) begin n_fail++; $display("FAIL oor_err_pulse: got %b want 0", sb_err); end
      sb_req(1'b0, 32'h0, 4'h0, 32'h0, ok);
      n_checks++;
      if (sb_rd_data !== 32'hC0DE00A0) begin
         n_fail++; $display("FAIL oor_no_write: got %h want c0de00a0", sb_rd_data);
      end
      sb_req(1'b0, 32'h1004, 4'h0, 32'h0, ok);
      n_checks++;
      if ({sb_rd_valid, sb_err, sb_rd_data} !== {2'b11, 32'h0}) begin
         n_fail++; $display("FAIL oor_rd: valid/err/data got %b/%b/%h want 1/1/0", sb_rd_valid, sb_err, sb_rd_data);
      end
   endtask

   task automatic test_reset_abort();
      bit ok;
      wr_idx = 20;
      if_start(1'b1, 32'h80, 4'd3, ok);
      run_cycles(1);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({if_busy, if_beat_ack} !== 2'b00) begin
         n_fail++; $display("FAIL abort_busy: busy/ack got %b want 00", {if_busy, if_beat_ack});
      end
      @(posedge clk); @(negedge clk);
      n_checks++;
      if ({if_busy, if_done, if_req_ready} !== 3'b000) begin
         n_fail++; $display("FAIL abort_in_reset: busy/done/ready got %b want 000", {if_busy, if_done, if_req_ready});
      end
      rst_n = 1'b1;
      run_cycles(4);
      n_checks++;
      if (ack_cyc.size() != 0 || done_at != -1) begin
         n_fail++; $display("FAIL abort_quiet: acks %0d done %0d want 0/-1", ack_cyc.size(), done_at);
      end
      if_start(1'b0, 32'h80, 4'd0, ok);
      run_cycles(3);
      n_checks++;
      if (ok !== 1'b1 || rd_beats.size() != 1 || done_at != 1) begin
         n_fail++; $display("FAIL abort_new_burst: ok %b beats %0d done %0d want 1/1/1", ok, rd_beats.size(), done_at);
      end else begin
         n_checks++;
         if (rd_beats[0] !== pat(20)) begin
            n_fail++; $display("FAIL abort_row8: got %h want %h", rd_beats[0], pat(20));
         end
      end
   endtask

   initial begin
      test_reset();
      test_sb_mask();
      test_back_to_back();
      test_arbitration();
      test_wrap_and_range();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
